hazard_scoreboard: RTL

Pipeline hazard detector for the five-stage ARM core; it is the producer side of the forwarding path. It tracks destination tags of instructions in flight through EXE, MEM and WB, raises a stall to IF/ID when the instruction in ID cannot proceed, and drives the MEM/WB destination and write-enable tags consumed by the forwarding unit. It sits beside the ID stage and advances in lockstep with the pipeline registers.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 86 ++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-side hazard scoreboard bus: instruction tags and pipeline controls in,
// stall request, per-stage destination/write-enable tags and stall counter out.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             forward_en;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             two_src;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             stall_count_clr;

  logic             hazard_stall;
  logic [REG_W-1:0] Dest_EXE;
  logic [REG_W-1:0] Dest_MEM;
  logic [REG_W-1:0] Dest_WB;
  logic             WB_EXE;
  logic             WB_MEM;
  logic             WB_WB;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output freeze, forward_en, flush, id_valid, src1, src2, two_src,
           id_dest, id_wb_en, id_mem_read, stall_count_clr,
    input  hazard_stall, Dest_EXE, Dest_MEM, Dest_WB,
           WB_EXE, WB_MEM, WB_WB, stall_count
  );

  modport slave (
    input  freeze, forward_en, flush, id_valid, src1, src2, two_src,
           id_dest, id_wb_en, id_mem_read, stall_count_clr,
    output hazard_stall, Dest_EXE, Dest_MEM, Dest_WB,
           WB_EXE, WB_MEM, WB_WB, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination tags in EXE/MEM/WB, raises the ID stall for RAW hazards
// and publishes the per-stage tags used by the forwarding unit.
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave sb
);

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb;
    logic             mem_read;
  } entry_t;

  localparam int EXE = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  entry_t [2:0]     stage_q, stage_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       hit;
  logic             raw_hazard;
  logic             stall;

  for (genvar gi = 0; gi < 3; gi++) begin : g_match
    assign hit[gi] = stage_q[gi].wb &&
                     ((sb.src1 == stage_q[gi].dest) ||
                      (sb.two_src && (sb.src2 == stage_q[gi].dest)));
  end

  // WB is never checked: the register file writes on the falling edge.
  always_comb begin
    raw_hazard = 1'b0;
    if (sb.forward_en) begin
      raw_hazard = hit[EXE] && stage_q[EXE].mem_read;
    end else begin
      raw_hazard = hit[EXE] || hit[MEM];
    end
  end

  assign stall = sb.id_valid && !sb.flush && raw_hazard;

  always_comb begin
    stage_d = stage_q;
    count_d = count_q;
    if (!sb.freeze) begin
      stage_d[WB]  = stage_q[MEM];
      stage_d[MEM] = stage_q[EXE];
      if (stall || sb.flush || !sb.id_valid) begin
        stage_d[EXE] = '0;
      end else begin
        stage_d[EXE] = '{dest: sb.id_dest, wb: sb.id_wb_en, mem_read: sb.id_mem_read};
      end
      if (stall && !(&count_q)) begin
        count_d = count_q + 1'b1;
      end
    end
    // Clear wins over increment and applies even while frozen.
    if (sb.stall_count_clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      count_q <= count_d;
    end
  end

  assign sb.hazard_stall = stall;
  assign sb.Dest_EXE     = stage_q[EXE].dest;
  assign sb.Dest_MEM     = stage_q[MEM].dest;
  assign sb.Dest_WB      = stage_q[WB].dest;
  assign sb.WB_EXE       = stage_q[EXE].wb;
  assign sb.WB_MEM       = stage_q[MEM].wb;
  assign sb.WB_WB        = stage_q[WB].wb;
  assign sb.stall_count  = count_q;

endmodule
